load_buffer: RTL and testbench



---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lb_alloc_enc.sv | 25 ++
 rtl/load_buffer.sv | 169 ++++++++++++++++
 tb/tb_load_buffer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and widths for the load buffer and its ROB-facing buses.
package lsu_pkg;

    localparam int TAGW      = 6;
    localparam int NENT      = 8;
    localparam int IDXW      = $clog2(NENT);
    localparam int ADDRW     = 32;
    localparam int DATAW     = 32;

    // Result bus to the ROB: {tag, data}
    localparam int CDB_W     = TAGW + DATAW;
    // Store report to the ROB: {tag, addr, data}
    localparam int ST2ROB_W  = TAGW + ADDRW + DATAW;
    // Issue request as seen by the buffer: {store, tag, addr}
    localparam int LSU_REQ_W = 1 + TAGW + ADDRW;

    typedef struct packed {
        logic [TAGW-1:0]  tag;
        logic [DATAW-1:0] data;
    } cdb_t;

    typedef struct packed {
        logic [TAGW-1:0]  tag;
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] data;
    } st2rob_t;

    typedef struct packed {
        logic             store;
        logic [TAGW-1:0]  tag;
        logic [ADDRW-1:0] addr;
    } lsu_req_t;

endpackage

// File: rtl/lb_alloc_enc.sv
// Lowest-free-slot finder for the load buffer. Slot 0 means "no entry",
// so only slots 1..NENT-1 are candidates.
module lb_alloc_enc #(
    parameter int NENT = 8
) (
    input  logic [NENT-1:1]         free_vec,
    output logic [$clog2(NENT)-1:0] idx,
    output logic                    none
);

    localparam int IW = $clog2(NENT);

    // Scan high to low so the last hit, i.e. the lowest free slot, wins
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = NENT - 1; i >= 1; i--) begin
            if (free_vec[i]) begin
                idx  = IW'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/load_buffer.sv
// Load/store execution unit paired with the ROB. Loads occupy a slot until
// the ROB commits them, and committed stores are snooped so that a load
// which read memory before an older store landed is flagged as stale.
module load_buffer #(
    parameter int NENT = 8,
    parameter int TAGW = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        kill,
    input  logic                        lsu_valid,
    output logic                        lsu_ready,
    input  logic                        lsu_store,
    input  logic [TAGW-1:0]             lsu_tag,
    input  logic [31:0]                 lsu_addr,
    input  logic [31:0]                 lsu_data,
    output logic [31:0]                 dmem_raddr,
    input  logic [31:0]                 dmem_rdata,
    output logic [lsu_pkg::CDB_W-1:0]   cdb3,
    output logic                        loadbuf_en,
    output logic [$clog2(NENT)-1:0]     loadbuf_free_entry,
    output logic [lsu_pkg::ST2ROB_W-1:0] store2rob,
    input  logic                        dmem_we,
    input  logic [31:0]                 store_addr,
    input  logic [$clog2(NENT)-1:0]     loadbuf_commit_entry,
    output logic                        misload
);

    import lsu_pkg::*;

    localparam int IW = $clog2(NENT);

    // Per-slot state; bit/element 0 is never set since slot 0 means "none"
    logic [NENT-1:0] busy_q, busy_d;
    logic [NENT-1:0] stale_q, stale_d;
    logic [29:0]     addr_q [NENT];
    logic [29:0]     addr_d [NENT];

    logic [IW-1:0]   alloc_idx;
    logic            alloc_none;
    logic            issue_ok;
    logic            load_acc;
    logic            store_acc;
    lsu_req_t        req;

    // Result and store stages, one cycle behind issue
    logic            ld_valid_q;
    logic [TAGW-1:0] ld_tag_q;
    logic [IW-1:0]   ld_slot_q;
    st2rob_t         st_q;
    cdb_t            cdb_out;

    assign req.store = lsu_store;
    assign req.tag   = lsu_tag;
    assign req.addr  = lsu_addr;

    lb_alloc_enc #(
        .NENT (NENT)
    ) u_alloc (
        .free_vec (~busy_q[NENT-1:1]),
        .idx      (alloc_idx),
        .none     (alloc_none)
    );

    // Ready depends only on registered occupancy, so a slot freed by a
    // commit is not visible to issue until the following cycle.
    assign lsu_ready  = |(~busy_q[NENT-1:1]);
    assign issue_ok   = lsu_valid && lsu_ready && !kill;
    assign load_acc   = issue_ok && !req.store && !alloc_none;
    assign store_acc  = issue_ok && req.store;
    assign dmem_raddr = load_acc ? req.addr : 32'h0;

    assign misload = (loadbuf_commit_entry != '0)
                  && busy_q[loadbuf_commit_entry]
                  && stale_q[loadbuf_commit_entry];

    // Slot bookkeeping: snoop, then allocate, then commit, then kill, so that
    // later effects override earlier ones in the same cycle
    always_comb begin
        busy_d  = busy_q;
        stale_d = stale_q;
        addr_d  = addr_q;

        if (dmem_we) begin
            for (int i = 1; i < NENT; i++) begin
                if (busy_q[i] && (addr_q[i] == store_addr[31:2])) begin
                    stale_d[i] = 1'b1;
                end
            end
        end

        if (load_acc) begin
            busy_d[alloc_idx]  = 1'b1;
            addr_d[alloc_idx]  = req.addr[31:2];
            stale_d[alloc_idx] = dmem_we && (req.addr[31:2] == store_addr[31:2]);
        end

        if (loadbuf_commit_entry != '0) begin
            busy_d[loadbuf_commit_entry]  = 1'b0;
            stale_d[loadbuf_commit_entry] = 1'b0;
        end

        if (kill) begin
            busy_d  = '0;
            stale_d = '0;
        end

        busy_d[0]  = 1'b0;
        stale_d[0] = 1'b0;
    end

    // Slot state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            stale_q <= '0;
            for (int i = 0; i < NENT; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            stale_q <= stale_d;
            for (int i = 0; i < NENT; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    // Result and store stages; an issue dropped by kill never enters them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_valid_q <= 1'b0;
            ld_tag_q   <= '0;
            ld_slot_q  <= '0;
            st_q       <= '0;
        end else begin
            ld_valid_q <= load_acc;
            if (load_acc) begin
                ld_tag_q  <= req.tag;
                ld_slot_q <= alloc_idx;
            end else begin
                ld_tag_q  <= '0;
                ld_slot_q <= '0;
            end
            if (store_acc) begin
                st_q.tag  <= req.tag;
                st_q.addr <= req.addr;
                st_q.data <= lsu_data;
            end else begin
                st_q <= '0;
            end
        end
    end

    // The RAM answers one cycle after the address, aligning with the stage
    always_comb begin
        cdb_out = '0;
        if (ld_valid_q) begin
            cdb_out.tag  = ld_tag_q;
            cdb_out.data = dmem_rdata;
        end
    end

    assign cdb3               = cdb_out;
    assign loadbuf_en         = ld_valid_q;
    assign loadbuf_free_entry = ld_slot_q;
    assign store2rob          = st_q;

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer with a 1-cycle-latency RAM model.
module tb_load_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        kill;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_store;
    logic [5:0]  lsu_tag;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_data;
    logic [31:0] dmem_raddr;
    logic [31:0] dmem_rdata = 32'h0;
    logic [37:0] cdb3;
    logic        loadbuf_en;
    logic [2:0]  loadbuf_free_entry;
    logic [69:0] store2rob;
    logic        dmem_we;
    logic [31:0] store_addr;
    logic [2:0]  loadbuf_commit_entry;
    logic        misload;

    int n_cmp = 0;
    int n_err = 0;

    load_buffer dut (
        .clk                  (clk),
        .reset                (reset),
        .kill                 (kill),
        .lsu_valid            (lsu_valid),
        .lsu_ready            (lsu_ready),
        .lsu_store            (lsu_store),
        .lsu_tag              (lsu_tag),
        .lsu_addr             (lsu_addr),
        .lsu_data             (lsu_data),
        .dmem_raddr           (dmem_raddr),
        .dmem_rdata           (dmem_rdata),
        .cdb3                 (cdb3),
        .loadbuf_en           (loadbuf_en),
        .loadbuf_free_entry   (loadbuf_free_entry),
        .store2rob            (store2rob),
        .dmem_we              (dmem_we),
        .store_addr           (store_addr),
        .loadbuf_commit_entry (loadbuf_commit_entry),
        .misload              (misload)
    );

    always #5 clk = ~clk;

    // RAM contents: a fixed word at 0x100, an address-derived pattern elsewhere
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A0000);
    endfunction

    // Synchronous-read RAM with one cycle of latency
    always @(posedge clk) begin
        dmem_rdata <= ram_word(dmem_raddr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic s, input logic [5:0] t,
                                  input logic [31:0] a, input logic [31:0] d);
        lsu_valid = v;
        lsu_store = s;
        lsu_tag   = t;
        lsu_addr  = a;
        lsu_data  = d;
        #1;
    endtask

    task automatic check_output(input string name, input logic [69:0] obs,
                                input logic [69:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        kill = 1'b0;
        dmem_we = 1'b0;
        store_addr = 32'h0;
        loadbuf_commit_entry = 3'd0;
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check_output("rst_ready",   70'(lsu_ready), 70'd1);
        check_output("rst_cdb3",    70'(cdb3), 70'd0);
        check_output("rst_en",      70'(loadbuf_en), 70'd0);
        check_output("rst_entry",   70'(loadbuf_free_entry), 70'd0);
        check_output("rst_st2rob",  store2rob, 70'd0);
        check_output("rst_misload", 70'(misload), 70'd0);
        check_output("rst_raddr",   70'(dmem_raddr), 70'd0);

        reset = 1'b0;
        tick();

        // Load tag 5 @0x100
        apply_stimulus(1'b1, 1'b0, 6'd5, 32'h100, 32'h0);
        check_output("ld1_raddr", 70'(dmem_raddr), 70'h100);
        tick();
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        check_output("ld1_cdb3",  70'(cdb3), 70'({6'd5, 32'hDEADBEEF}));
        check_output("ld1_en",    70'(loadbuf_en), 70'd1);
        check_output("ld1_entry", 70'(loadbuf_free_entry), 70'd1);
        loadbuf_commit_entry = 3'd1;
        #1;
        check_output("ld1_commit_misload", 70'(misload), 70'd0);
        tick();
        loadbuf_commit_entry = 3'd0;
        #1;
        check_output("ld1_cdb3_idle", 70'(cdb3), 70'd0);
        check_output("ld1_en_idle",   70'(loadbuf_en), 70'd0);

        // Store tag 9 @0x40 data 0x1234
        apply_stimulus(1'b1, 1'b1, 6'd9, 32'h40, 32'h1234);
        check_output("st_raddr", 70'(dmem_raddr), 70'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        check_output("st_st2rob", store2rob, {6'd9, 32'h40, 32'h1234});
        check_output("st_en",     70'(loadbuf_en), 70'd0);
        tick();
        check_output("st_st2rob_once", store2rob, 70'd0);

        // Stale load: load @0x200, snoop store @0x200, commit -> misload
        apply_stimulus(1'b1, 1'b0, 6'd7, 32'h200, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        check_output("stale_entry", 70'(loadbuf_free_entry), 70'd1);
        dmem_we = 1'b1;
        store_addr = 32'h200;
        tick();
        dmem_we = 1'b0;
        loadbuf_commit_entry = 3'd1;
        #1;
        check_output("stale_misload", 70'(misload), 70'd1);
        tick();
        loadbuf_commit_entry = 3'd0;
        apply_stimulus(1'b1, 1'b0, 6'd8, 32'h200, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        check_output("stale_slot_reused", 70'(loadbuf_free_entry), 70'd1);

        // Neighbouring word snoop does not mark the load stale
        dmem_we = 1'b1;
        store_addr = 32'h204;
        tick();
        dmem_we = 1'b0;
        loadbuf_commit_entry = 3'd1;
        #1;
        check_output("nbr_misload", 70'(misload), 70'd0);
        tick();
        loadbuf_commit_entry = 3'd0;

        // Snoop hitting the slot being allocated in the same cycle
        dmem_we = 1'b1;
        store_addr = 32'h240;
        apply_stimulus(1'b1, 1'b0, 6'd11, 32'h240, 32'h0);
        tick();
        dmem_we = 1'b0;
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        check_output("alloc_snoop_cdb3", 70'(cdb3), 70'({6'd11, 32'h5A5A0240}));
        loadbuf_commit_entry = 3'd1;
        #1;
        check_output("alloc_snoop_misload", 70'(misload), 70'd1);
        tick();
        loadbuf_commit_entry = 3'd0;

        // Snoop and commit on the same slot in the same cycle: commit wins
        apply_stimulus(1'b1, 1'b0, 6'd12, 32'h280, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        dmem_we = 1'b1;
        store_addr = 32'h280;
        loadbuf_commit_entry = 3'd1;
        #1;
        check_output("snoopcommit_misload", 70'(misload), 70'd0);
        tick();
        dmem_we = 1'b0;
        loadbuf_commit_entry = 3'd0;
        apply_stimulus(1'b1, 1'b0, 6'd13, 32'h2C0, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        check_output("snoopcommit_entry", 70'(loadbuf_free_entry), 70'd1);
        loadbuf_commit_entry = 3'd1;
        #1;
        check_output("snoopcommit_after_misload", 70'(misload), 70'd0);
        tick();
        loadbuf_commit_entry = 3'd0;

        // Fill all seven slots
        for (int k = 1; k <= 7; k++) begin
            apply_stimulus(1'b1, 1'b0, 6'(k), 32'h300 + 32'(4 * k), 32'h0);
            tick();
            check_output($sformatf("fill_entry%0d", k), 70'(loadbuf_free_entry), 70'(k));
        end
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        check_output("full_ready", 70'(lsu_ready), 70'd0);
        apply_stimulus(1'b1, 1'b0, 6'd20, 32'h400, 32'h0);
        check_output("full_raddr", 70'(dmem_raddr), 70'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        check_output("full_no_result", 70'(loadbuf_en), 70'd0);
        loadbuf_commit_entry = 3'd3;
        #1;
        check_output("full_commit_ready_same", 70'(lsu_ready), 70'd0);
        tick();
        loadbuf_commit_entry = 3'd0;
        #1;
        check_output("full_commit_ready_next", 70'(lsu_ready), 70'd1);
        apply_stimulus(1'b1, 1'b0, 6'd21, 32'h500, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        check_output("refill_entry", 70'(loadbuf_free_entry), 70'd3);
        check_output("refill_cdb3",  70'(cdb3), 70'({6'd21, 32'h5A5A0500}));
        check_output("refill_ready", 70'(lsu_ready), 70'd0);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        #1;
        check_output("kill_ready", 70'(lsu_ready), 70'd1);

        // Load issued together with kill is dropped
        kill = 1'b1;
        apply_stimulus(1'b1, 1'b0, 6'd22, 32'h100, 32'h0);
        check_output("killiss_raddr", 70'(dmem_raddr), 70'd0);
        tick();
        kill = 1'b0;
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        check_output("killiss_en",   70'(loadbuf_en), 70'd0);
        check_output("killiss_cdb3", 70'(cdb3), 70'd0);

        // Load followed by kill: slot released
        apply_stimulus(1'b1, 1'b0, 6'd23, 32'h100, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        #1;
        check_output("killnext_en",   70'(loadbuf_en), 70'd0);
        check_output("killnext_cdb3", 70'(cdb3), 70'd0);
        apply_stimulus(1'b1, 1'b0, 6'd24, 32'h104, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        check_output("killnext_entry", 70'(loadbuf_free_entry), 70'd1);
        kill = 1'b1;
        tick();
        kill = 1'b0;

        // Reset in the middle of a burst
        apply_stimulus(1'b1, 1'b0, 6'd25, 32'h600, 32'h0);
        tick();
        apply_stimulus(1'b1, 1'b0, 6'd26, 32'h604, 32'h0);
        tick();
        apply_stimulus(1'b1, 1'b1, 6'd28, 32'h80, 32'hAA);
        check_output("burst_cdb3", 70'(cdb3), 70'({6'd26, 32'h5A5A0604}));
        reset = 1'b1;
        #1;
        check_output("midrst_cdb3",  70'(cdb3), 70'd0);
        check_output("midrst_en",    70'(loadbuf_en), 70'd0);
        check_output("midrst_entry", 70'(loadbuf_free_entry), 70'd0);
        check_output("midrst_raddr", 70'(dmem_raddr), 70'd0);
        check_output("midrst_ready", 70'(lsu_ready), 70'd1);
        tick();
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
        check_output("midrst_st2rob", store2rob, 70'd0);
        tick();
        check_output("midrst_st2rob_after", store2rob, 70'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
